// File: rtl/sec_display_driver.sv
// rtl/sec_display_driver.sv - seconds value to BCD via double-dabble FSM, 2-digit muxed 7-seg driver
// Optional build macro: LEADING_ZERO_BLANK_EN (blank the tens digit when it is 0)
module sec_display_driver #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sec,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       busy
);

  localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        sec_q;
  logic [7:0]        last_bin;
  // {hund[1:0], tens[3:0], ones[3:0], bin[7:0]}
  logic [17:0]       sr;
  logic [16:0]       sr_adj;
  logic [2:0]        bit_cnt;
  logic [SCAN_W-1:0] scan_cnt;
  logic              digit_sel;
  logic [3:0]        digit;
  logic [6:0]        seg_nxt;

  // Active-low segment pattern {g,f,e,d,c,b,a}; 4'hF is the out-of-range dash
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      4'hF:    seg7 = 7'b0111111;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: start on a new value, 8 shifts, then publish
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sec_q != last_bin) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 3'd7)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction on BCD nibbles; hundreds never exceeds 2 so it needs none
  always_comb begin
    sr_adj = sr[16:0];
    if (sr[11:8]  >= 4'd5) sr_adj[11:8]  = sr[11:8]  + 4'd3;
    if (sr[15:12] >= 4'd5) sr_adj[15:12] = sr[15:12] + 4'd3;
  end

  // Input register and conversion datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q    <= 8'd0;
      last_bin <= 8'd0;
      sr       <= 18'd0;
      bit_cnt  <= 3'd0;
      busy     <= 1'b0;
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
    end else begin
      sec_q <= sec;
      case (state)
        IDLE: begin
          if (sec_q != last_bin) begin
            last_bin <= sec_q;
            busy     <= 1'b1;
            bit_cnt  <= 3'd0;
            sr       <= {10'b0, sec_q};
          end
        end
        SHIFT: begin
          sr      <= {sr_adj, 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
        end
        DONE: begin
          busy <= 1'b0;
          // Hundreds digit nonzero means the value is above 99
          if (sr[17:16] != 2'b00) begin
            bcd_tens <= 4'hF;
            bcd_ones <= 4'hF;
          end else begin
            bcd_tens <= sr[15:12];
            bcd_ones <= sr[11:8];
          end
        end
        default: ;
      endcase
    end
  end

  // Refresh scan: each digit slot lasts REFRESH_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_sel <= 1'b0;
    end else if (scan_cnt == SCAN_W'(REFRESH_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_sel <= ~digit_sel;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Segment pattern for the digit currently selected
  always_comb begin
    digit   = digit_sel ? bcd_tens : bcd_ones;
    seg_nxt = seg7(digit);
`ifdef LEADING_ZERO_BLANK_EN
    if (digit_sel && (bcd_tens == 4'd0)) seg_nxt = 7'b1111111;
`else
`endif
  end

  // Registered display outputs, one cycle behind digit_sel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 7'b1000000;
      an  <= 2'b10;
    end else begin
      seg <= seg_nxt;
      an  <= digit_sel ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: tb/tb_sec_display_driver.sv
// tb/tb_sec_display_driver.sv - self-checking bench for sec_display_driver
module tb_sec_display_driver;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sec;
  logic [6:0] seg;
  logic [1:0] an;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int last_v = 0;

  sec_display_driver #(.REFRESH_DIV(RD)) dut (
    .clk      (clk),
    .rst      (rst),
    .sec      (sec),
    .seg      (seg),
    .an       (an),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_tens(input int v);
    return (v > 99) ? 4'hF : 4'(v / 10);
  endfunction

  function automatic logic [3:0] exp_ones(input int v);
    return (v > 99) ? 4'hF : 4'(v % 10);
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [0:9];
    tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100;
    tbl[3] = 7'b0110000; tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
    tbl[6] = 7'b0000010; tbl[7] = 7'b1111000; tbl[8] = 7'b0000000;
    tbl[9] = 7'b0010000;
    if (d == 4'hF) return 7'b0111111;
    if (d > 4'd9)  return 7'b1111111;
    return tbl[d];
  endfunction

  function automatic logic [6:0] exp_tens_seg(input int v);
    logic [6:0] s;
    s = seg_of(exp_tens(v));
`ifdef LEADING_ZERO_BLANK_EN
    if (exp_tens(v) == 4'd0) s = 7'b1111111;
`endif
    return s;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sec = 8'd0;
    step;
    step;
    total++; if (an !== 2'b10)         begin bad++; $display("FAIL reset_an got=%b want=10", an); end
    total++; if (seg !== 7'b1000000)   begin bad++; $display("FAIL reset_seg got=%b want=1000000", seg); end
    total++; if (bcd_tens !== 4'd0)    begin bad++; $display("FAIL reset_tens got=%h want=0", bcd_tens); end
    total++; if (bcd_ones !== 4'd0)    begin bad++; $display("FAIL reset_ones got=%h want=0", bcd_ones); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst = 1'b0;
    last_v = 0;
  endtask

  // Drive v before edge k; busy must be high after k+1..k+9 and results valid after k+10
  task automatic test_convert(input int v);
    sec = 8'(v);
    step;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL conv_busy_k v=%0d got=%b want=0", v, busy); end
    for (int i = 1; i <= 9; i++) begin
      step;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL conv_busy v=%0d edge=k+%0d got=%b want=1", v, i, busy); end
    end
    step;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL conv_busy_end v=%0d got=%b want=0", v, busy); end
    total++; if (bcd_tens !== exp_tens(v)) begin bad++; $display("FAIL conv_tens v=%0d got=%h want=%h", v, bcd_tens, exp_tens(v)); end
    total++; if (bcd_ones !== exp_ones(v)) begin bad++; $display("FAIL conv_ones v=%0d got=%h want=%h", v, bcd_ones, exp_ones(v)); end
    last_v = v;
  endtask

  // Anodes alternate in runs of RD and each slot shows the matching digit
  task automatic test_scan;
    logic [1:0] prev;
    int run;
    bit first;
    prev  = 2'b00;
    run   = 0;
    first = 1'b1;
    step;
    for (int i = 0; i < 3 * RD; i++) begin
      step;
      total++;
      if (an === 2'b01) begin
        if (seg !== exp_tens_seg(last_v)) begin
          bad++; $display("FAIL scan_tens_seg v=%0d got=%b want=%b", last_v, seg, exp_tens_seg(last_v));
        end
      end else if (an === 2'b10) begin
        if (seg !== seg_of(exp_ones(last_v))) begin
          bad++; $display("FAIL scan_ones_seg v=%0d got=%b want=%b", last_v, seg, seg_of(exp_ones(last_v)));
        end
      end else begin
        bad++; $display("FAIL scan_an v=%0d got=%b want=01or10", last_v, an);
      end
      if (i > 0 && an !== prev) begin
        if (!first) begin
          total++;
          if (run != RD) begin bad++; $display("FAIL scan_run v=%0d got=%0d want=%0d", last_v, run, RD); end
        end
        first = 1'b0;
        run = 1;
      end else begin
        run++;
      end
      prev = an;
    end
  endtask

  // 37 then 45 two cycles later: exactly two result updates, 3/7 then 4/5
  task automatic test_change_while_busy;
    logic [7:0] prev_bcd;
    int nchg;
    prev_bcd = {exp_tens(last_v), exp_ones(last_v)};
    nchg = 0;
    sec = 8'd37;
    for (int i = 1; i <= 30; i++) begin
      step;
      if (i == 2) sec = 8'd45;
      if ({bcd_tens, bcd_ones} !== prev_bcd) begin
        nchg++;
        total++;
        if (nchg == 1) begin
          if ({bcd_tens, bcd_ones} !== 8'h37 || i != 11) begin
            bad++; $display("FAIL busy_first got=%h at=%0d want=37 at=11", {bcd_tens, bcd_ones}, i);
          end
        end else if (nchg == 2) begin
          if ({bcd_tens, bcd_ones} !== 8'h45 || i != 21) begin
            bad++; $display("FAIL busy_second got=%h at=%0d want=45 at=21", {bcd_tens, bcd_ones}, i);
          end
        end else begin
          bad++; $display("FAIL busy_extra got=%h at=%0d want=none", {bcd_tens, bcd_ones}, i);
        end
        prev_bcd = {bcd_tens, bcd_ones};
      end
    end
    total++; if (nchg != 2) begin bad++; $display("FAIL busy_nchg got=%0d want=2", nchg); end
    last_v = 45;
  endtask

  // Re-presenting the converted value must not start a conversion
  task automatic test_equal;
    sec = 8'(last_v);
    for (int i = 0; i < 12; i++) begin
      step;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL equal_busy cyc=%0d got=%b want=0", i, busy); end
    end
    total++;
    if ({bcd_tens, bcd_ones} !== {exp_tens(last_v), exp_ones(last_v)}) begin
      bad++; $display("FAIL equal_bcd got=%h want=%h", {bcd_tens, bcd_ones}, {exp_tens(last_v), exp_ones(last_v)});
    end
  endtask

  // Asynchronous reset in the middle of a conversion, then a fresh conversion
  task automatic test_reset_mid(input int v);
    sec = 8'(v);
    step;
    step;
    step;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre got=%b want=1", busy); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (an !== 2'b10)       begin bad++; $display("FAIL mid_an got=%b want=10", an); end
    total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL mid_seg got=%b want=1000000", seg); end
    total++; if ({bcd_tens, bcd_ones} !== 8'h00) begin bad++; $display("FAIL mid_bcd got=%h want=00", {bcd_tens, bcd_ones}); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    step;
    rst = 1'b0;
    last_v = 0;
    test_convert(v);
  endtask

  initial begin
    int list [15];
    int v;
    list = '{37, 150, 59, 0, 7, 12, 68, 91, 24, 83, 76, 99, 100, 255, 3};
    rst = 1'b1;
    sec = 8'd0;
    test_reset;
    for (int i = 0; i < 4; i++) begin
      test_convert(list[i]);
      test_scan;
    end
    test_change_while_busy;
    test_scan;
    for (int i = 4; i < 15; i++) begin
      test_convert(list[i]);
      test_scan;
    end
    test_equal;
    test_reset_mid(88);
    test_scan;
    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 255));
      if (v == last_v) v = (v + 1) % 256;
      test_convert(v);
      test_scan;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
